memory_responder: RTL

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder.sv | 115 +++++++++++
 1 files changed

// File: rtl/memory_responder.sv
// Single-port 8-bit memory slave with a fixed, parameterised response latency.
// One access is in flight at a time; a new one is accepted whenever BUSY is low.
module memory_responder #(
  parameter int unsigned WAIT_CYC = 2,
  parameter int unsigned DEPTH    = 256
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       READ,
  input  logic       WRITE,
  input  logic [7:0] ADDR,
  input  logic [7:0] WDATA,
  output logic [7:0] RDATA,
  output logic       RVALID,
  output logic       WACK,
  output logic       BUSY,
  output logic       ERR
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            op_wr, op_wr_nxt;
  logic [AW-1:0]   addr_q, addr_nxt;
  logic [7:0]      wdata_q, wdata_nxt;
  logic            conflict;
  logic            enter_resp;
  logic [7:0]      mem [DEPTH];

  // State and latched request
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      op_wr   <= op_wr_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  // Next state; IDLE and RESP both accept because BUSY is low in each
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_wr_nxt  = op_wr;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    conflict   = 1'b0;
    enter_resp = 1'b0;
    case (state)
      S_WAIT: begin
        if (cnt == '0) begin
          state_nxt  = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        if (READ ^ WRITE) begin
          op_wr_nxt = WRITE;
          addr_nxt  = AW'(ADDR);
          wdata_nxt = WDATA;
          if (WAIT_CYC == 0) begin
            state_nxt  = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CW'(WAIT_CYC - 1);
          end
        end else if (READ & WRITE) begin
          conflict = 1'b1;
        end
      end
    endcase
  end

  // Registered outputs; *_nxt carries the request even when it was accepted this edge
  always_ff @(posedge CLK) begin
    if (RST) begin
      RDATA  <= 8'h00;
      RVALID <= 1'b0;
      WACK   <= 1'b0;
      BUSY   <= 1'b0;
      ERR    <= 1'b0;
    end else begin
      RVALID <= enter_resp & ~op_wr_nxt;
      WACK   <= enter_resp & op_wr_nxt;
      BUSY   <= (state_nxt == S_WAIT);
      ERR    <= conflict;
      if (enter_resp && !op_wr_nxt) begin
        RDATA <= mem[addr_nxt];
      end
    end
  end

  // Storage survives reset; a write aborted by reset is never committed
  always_ff @(posedge CLK) begin
    if (!RST && enter_resp && op_wr_nxt) begin
      mem[addr_nxt] <= wdata_nxt;
    end
  end

endmodule
